// File: rtl/tea_decrypt.sv
`default_nettype none
// ============================================================================
//  Module      : tea_decrypt
//  Description : Iterative TEA decryptor. Captures one 64-bit ciphertext
//                block with its 128-bit key and round constant, then runs
//                ROUNDS reverse Feistel rounds, one full round per clock.
//                Returns the plaintext together with a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tea_decrypt #(
    parameter int ROUNDS = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ready,
    input  logic [63:0]  data,
    input  logic [127:0] key,
    input  logic [31:0]  delta,
    output logic         done,
    output logic         work_in_progress,
    output logic [63:0]  decrypted_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0]  c_last_round = 8'(ROUNDS - 1);
    localparam logic [31:0] c_rounds     = 32'(ROUNDS);

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_y;
    logic [31:0] r_z;
    logic [31:0] r_sum;
    logic [7:0]  r_cnt;
    logic [31:0] r_k0;
    logic [31:0] r_k1;
    logic [31:0] r_k2;
    logic [31:0] r_k3;
    logic [31:0] r_delta;

    logic        w_capture;
    logic        w_last;
    logic [31:0] w_sum_init;
    logic [31:0] w_z_new;
    logic [31:0] w_y_new;

    assign w_capture  = (r_state == IDLE) && ready;
    assign w_last     = (r_state == RUN) && (r_cnt == c_last_round);

    // The decrypt schedule starts where the encryptor finished: delta*ROUNDS.
    assign w_sum_init = delta * c_rounds;

    // One reverse round: z is recovered first and the fresh z feeds the y update.
    assign w_z_new = r_z - (((r_y << 4) + r_k2) ^ (r_y + r_sum) ^ ((r_y >> 5) + r_k3));
    assign w_y_new = r_y - (((w_z_new << 4) + r_k0) ^ (w_z_new + r_sum) ^ ((w_z_new >> 5) + r_k1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: IDLE -> RUN on ready, RUN -> DONE on the last round, DONE -> IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (ready)  w_next_state = RUN;
            RUN:     if (w_last) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath and registered outputs: capture in IDLE, iterate in RUN, drop done in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y              <= 32'd0;
            r_z              <= 32'd0;
            r_sum            <= 32'd0;
            r_cnt            <= 8'd0;
            r_k0             <= 32'd0;
            r_k1             <= 32'd0;
            r_k2             <= 32'd0;
            r_k3             <= 32'd0;
            r_delta          <= 32'd0;
            done             <= 1'b0;
            work_in_progress <= 1'b0;
            decrypted_data   <= 64'd0;
        end else if (w_capture) begin
            r_y              <= data[63:32];
            r_z              <= data[31:0];
            r_k0             <= key[127:96];
            r_k1             <= key[95:64];
            r_k2             <= key[63:32];
            r_k3             <= key[31:0];
            r_delta          <= delta;
            r_sum            <= w_sum_init;
            r_cnt            <= 8'd0;
            work_in_progress <= 1'b1;
        end else if (r_state == RUN) begin
            r_y   <= w_y_new;
            r_z   <= w_z_new;
            r_sum <= r_sum - r_delta;
            r_cnt <= r_cnt + 8'd1;
            if (w_last) begin
                decrypted_data   <= {w_y_new, w_z_new};
                done             <= 1'b1;
                work_in_progress <= 1'b0;
            end
        end else if (r_state == DONE) begin
            done <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tea_decrypt.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tea_decrypt
//  Description : Self-checking bench for tea_decrypt (ROUNDS=32 and ROUNDS=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tea_decrypt;

    localparam int R = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         ready;
    logic         ready1;
    logic [63:0]  data;
    logic [127:0] key;
    logic [31:0]  delta;
    logic         done;
    logic         wip;
    logic [63:0]  dd;
    logic         done1;
    logic         wip1;
    logic [63:0]  dd1;

    int           total = 0;
    int           bad = 0;
    int           overlap = 0;
    logic [63:0]  last_exp;

    typedef struct {
        logic [63:0]  cipher;
        logic [127:0] key;
        logic [31:0]  delta;
        logic [63:0]  plain;
        int           pulse_at;
        int           change_at;
    } vec_t;

    vec_t         vecs[5];

    logic [63:0]  p_cur;
    logic [127:0] k_cur;
    logic [31:0]  d_cur;
    int           cnt;
    bit           got;

    tea_decrypt #(.ROUNDS(R)) dut (
        .clk(clk), .rst(rst), .ready(ready), .data(data), .key(key), .delta(delta),
        .done(done), .work_in_progress(wip), .decrypted_data(dd)
    );

    tea_decrypt #(.ROUNDS(1)) dut1 (
        .clk(clk), .rst(rst), .ready(ready1), .data(data), .key(key), .delta(delta),
        .done(done1), .work_in_progress(wip1), .decrypted_data(dd1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ((done && wip) || (done1 && wip1)) overlap++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Reference TEA encryptor (standard form).
    function automatic logic [63:0] tea_enc(input logic [63:0] p, input logic [127:0] k,
                                            input logic [31:0] d, input int n);
        logic [31:0] y, z, s;
        y = p[63:32];
        z = p[31:0];
        s = 32'd0;
        for (int i = 0; i < n; i++) begin
            s = s + d;
            y = y + (((z << 4) + k[127:96]) ^ (z + s) ^ ((z >> 5) + k[95:64]));
            z = z + (((y << 4) + k[63:32]) ^ (y + s) ^ ((y >> 5) + k[31:0]));
        end
        return {y, z};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_block(input string name, input logic [63:0] c, input logic [127:0] k,
                             input logic [31:0] d, input logic [63:0] exp,
                             input int pulse_at, input int change_at);
        int cyc;
        bit hit, wip_ok, held_ok, quiet_ok;
        hit = 0; wip_ok = 1; held_ok = 1; quiet_ok = 1;
        @(negedge clk);
        data = c; key = k; delta = d; ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        cyc = 1;
        while (!hit && cyc <= R + 8) begin
            if (done) hit = 1;
            else begin
                if (wip !== 1'b1) wip_ok = 0;
                if (dd !== last_exp) held_ok = 0;
                ready = 1'b0;
                if (cyc == pulse_at) begin ready = 1'b1; data = ~c; end
                if (cyc == change_at) begin data = ~c; key = ~k; delta = d + 32'd1; end
                @(negedge clk);
                cyc++;
            end
        end
        check({name, "_latency"}, hit ? 64'(cyc) : 64'hFFFF, 64'(R + 1));
        check({name, "_data"}, dd, exp);
        check({name, "_wip_run"}, 64'(wip_ok), 64'd1);
        check({name, "_held"}, 64'(held_ok), 64'd1);
        check({name, "_wip_at_done"}, 64'(wip), 64'd0);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check({name, "_pulse"}, 64'(done), 64'd0);
        repeat (4) begin
            if (done || wip) quiet_ok = 0;
            @(negedge clk);
        end
        check({name, "_quiet"}, 64'(quiet_ok), 64'd1);
        last_exp = exp;
    endtask

    initial begin
        rst = 1'b1; ready = 1'b0; ready1 = 1'b0;
        data = 64'd0; key = 128'd0; delta = 32'd0;
        last_exp = 64'd0;
        repeat (3) @(negedge clk);
        check("reset_done", 64'(done), 64'd0);
        check("reset_wip", 64'(wip), 64'd0);
        check("reset_data", dd, 64'd0);
        rst = 1'b0;

        vecs[0] = '{64'h41EA3A0A_94BAA940, 128'd0, 32'h9E3779B9, 64'd0, -1, -1};
        vecs[1] = '{tea_enc(64'd5, 128'd0, 32'h9E3779B9, R), 128'd0, 32'h9E3779B9, 64'd5, -1, -1};
        vecs[2] = '{tea_enc(64'h01234567_89ABCDEF, 128'h00112233_44556677_8899AABB_CCDDEEFF, 32'h9E3779B9, R),
                    128'h00112233_44556677_8899AABB_CCDDEEFF, 32'h9E3779B9, 64'h01234567_89ABCDEF, 10, -1};
        vecs[3] = '{tea_enc(64'hFFFFFFFF_FFFFFFFF, {128{1'b1}}, 32'h9E3779B9, R),
                    {128{1'b1}}, 32'h9E3779B9, 64'hFFFFFFFF_FFFFFFFF, -1, 5};
        vecs[4] = '{tea_enc(64'h80000000_00000001, 128'hDEADBEEF_01020304_CAFEF00D_A5A5A5A5, 32'd1, R),
                    128'hDEADBEEF_01020304_CAFEF00D_A5A5A5A5, 32'd1, 64'h80000000_00000001, -1, -1};

        for (int i = 0; i < 5; i++) begin
            run_block($sformatf("vec%0d", i), vecs[i].cipher, vecs[i].key, vecs[i].delta,
                      vecs[i].plain, vecs[i].pulse_at, vecs[i].change_at);
        end

        // Back-to-back blocks with ready held high.
        @(negedge clk);
        p_cur = {$urandom(), $urandom()};
        k_cur = {$urandom(), $urandom(), $urandom(), $urandom()};
        d_cur = $urandom();
        data = tea_enc(p_cur, k_cur, d_cur, R); key = k_cur; delta = d_cur;
        ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cnt = 0;
            got = 0;
            while (!got && cnt < 60) begin
                @(negedge clk);
                cnt++;
                if (done) got = 1;
            end
            check("b2b_data", got ? dd : ~p_cur, p_cur);
            if (i > 0) check("b2b_period", 64'(cnt), 64'(R + 2));
            if (!got) break;
            if (i < 99) begin
                p_cur = {$urandom(), $urandom()};
                k_cur = {$urandom(), $urandom(), $urandom(), $urandom()};
                d_cur = $urandom();
                data = tea_enc(p_cur, k_cur, d_cur, R); key = k_cur; delta = d_cur;
            end else begin
                ready = 1'b0;
            end
        end
        ready = 1'b0;
        repeat (3) @(negedge clk);
        last_exp = p_cur;

        // Reset in the middle of a block.
        data = tea_enc(64'h11112222_33334444, 128'h5, 32'h9E3779B9, R);
        key = 128'h5; delta = 32'h9E3779B9; ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        repeat (15) @(negedge clk);
        check("midrst_wip_before", 64'(wip), 64'd1);
        rst = 1'b1;
        #1;
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_wip", 64'(wip), 64'd0);
        check("midrst_data", dd, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        last_exp = 64'd0;
        run_block("after_rst", tea_enc(64'hCAFEBABE_12345678, 128'h1, 32'h9E3779B9, R),
                  128'h1, 32'h9E3779B9, 64'hCAFEBABE_12345678, -1, -1);

        // Single-round configuration.
        @(negedge clk);
        key = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        delta = 32'h9E3779B9;
        data = tea_enc(64'h00C0FFEE_BADC0DE5, key, delta, 1);
        ready1 = 1'b1;
        @(negedge clk);
        ready1 = 1'b0;
        check("r1_wip", 64'(wip1), 64'd1);
        check("r1_done_early", 64'(done1), 64'd0);
        @(negedge clk);
        check("r1_done", 64'(done1), 64'd1);
        check("r1_data", dd1, 64'h00C0FFEE_BADC0DE5);
        @(negedge clk);
        check("r1_pulse", 64'(done1), 64'd0);

        check("done_wip_overlap", 64'(overlap), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
